// File: rtl/shftreg_burst.sv
// Multi-lane bidirectional shift register with a counted-burst shift engine.
// Optional feature: define SHFTREG_ROTATE_EN to add the rot input (exiting lane fed back).
module shftreg_burst #(
  parameter int WIDTH = 8,
  parameter int LANE  = 1,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_n,
  input  logic [WIDTH-1:0] p_in,
  input  logic             shift_n,
  input  logic             dir,
  input  logic [LANE-1:0]  s_in,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
`ifdef SHFTREG_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] p_out,
  output logic [LANE-1:0]  s_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic             eff_dir;
  logic [LANE-1:0]  feed;

  function automatic logic [WIDTH-1:0] step_fn(input logic [WIDTH-1:0] d,
                                               input logic right,
                                               input logic [LANE-1:0] f);
    if (right) step_fn = {f, d[WIDTH-1:LANE]};
    else       step_fn = {d[WIDTH-LANE-1:0], f};
  endfunction

  // A running burst keeps its latched direction; idle steps follow the live pin.
  assign eff_dir = (state_q == SHIFT) ? dir_q : dir;
  assign s_out   = eff_dir ? data_q[LANE-1:0] : data_q[WIDTH-1 -: LANE];

`ifdef SHFTREG_ROTATE_EN
  assign feed = rot ? s_out : s_in;
`else
  assign feed = s_in;
`endif

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    data_d  = data_q;
    done_d  = 1'b0;
    if (!load_n) begin
      // Parallel load wins over everything and silently aborts a burst.
      data_d  = p_in;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (count == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = SHIFT;
              rem_d   = count;
              dir_d   = dir;
            end
          end else if (!shift_n) begin
            data_d = step_fn(data_q, eff_dir, feed);
          end
        end
        SHIFT: begin
          data_d = step_fn(data_q, eff_dir, feed);
          rem_d  = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign p_out = data_q;
  assign busy  = (state_q == SHIFT);
  assign done  = done_q;

endmodule

// File: doc/shftreg_burst.md
# shftreg_burst

Parametrised, multi-lane, bidirectional shift register with a counted-burst shift engine. It extends the basic load/shift register:
- configurable data and lane width;
- left/right direction;
- an autonomous N-step shift sequence with busy/done status.

It serves serializer/deserializer front-ends and scan-style register chains where a controller requests a fixed number of shifts and waits for completion.

## Interface

Parameters:
- WIDTH, 8: register width in bits; must be a multiple of LANE.
- LANE, 1: bits moved per shift step.
- CNT_W, 4: width of the burst step count.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- load_n  in  1  active-low parallel load of p_in.
- p_in  in  WIDTH  parallel load data.
- shift_n  in  1  active-low single manual shift step (idle only).
- dir  in  1  0 = shift toward MSB (left), 1 = toward LSB (right).
- s_in  in  LANE  serial data entering on each shift step.
- start  in  1  request a burst of count steps.
- count  in  CNT_W  burst step count, sampled with start.
- p_out  out  WIDTH  register contents.
- s_out  out  LANE  lane that will exit on the next step; combinational from p_out and the effective direction.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse when a burst completes.

The following is decided: one clock, named clk; reset rst_n is synchronous and active-low.

## Operation

- Reset (rst_n low at an edge): p_out = 0, busy = 0, done = 0, step counter = 0, state = IDLE. Reset overrides every other input.
- Left step: p_out <= {p_out[WIDTH-LANE-1:0], s_in}, and s_out = p_out[WIDTH-1 -: LANE].
- Right step: p_out <= {s_in, p_out[WIDTH-1:LANE]}, and s_out = p_out[LANE-1:0].
- Priority per edge, highest first: rst_n, load_n, burst step, start, shift_n, hold.

FSM states:
- IDLE
  - load_n = 0: p_out <= p_in.
  - Otherwise, start = 1: latch dir_q = dir and rem = count; go to SHIFT and set busy = 1. No shift on this edge.
  - count = 0 at start: stay in IDLE, pulse done, no shift.
  - Otherwise, shift_n = 0: one step using the live dir.
- SHIFT
  - Each edge performs one step in dir_q, with s_in sampled live, and decrements rem.
  - The edge where rem goes 1 -> 0: return to IDLE, busy = 0, done = 1 for the following cycle.
- Abort and ignored inputs during SHIFT:
  - load_n = 0 aborts the burst: p_out <= p_in, go to IDLE, busy = 0, no done pulse.
  - start and shift_n are ignored.
- Direction:
  - dir changes during SHIFT have no effect.
  - s_out uses dir_q while busy and live dir while idle.
- done is never asserted together with busy.

## Timing

- p_out, busy and done are registered. s_out is combinational.
- Burst of N ≥ 1 accepted at edge k:
  - steps occur at edges k+1 … k+N;
  - busy is high from after edge k through edge k+N;
  - done is high for the cycle after edge k+N.
  - Total latency is N+1 cycles.
- A new start is accepted on the edge where done is high, giving back-to-back bursts with one idle edge between them.
- Reset mid-burst clears everything on that edge; no done pulse.

## Configuration

- SHFTREG_ROTATE_EN defined:
  - Adds input port rot (1 bit).
  - When rot = 1, every step (manual or burst) feeds back the exiting lane (s_out) instead of s_in, so WIDTH/LANE steps restore the original contents.
  - rot is sampled live each step.
- SHFTREG_ROTATE_EN undefined: the rot port is absent; steps always use s_in.

## Test plan

- Reset: drive rst_n = 0 with load_n = 0 and p_in = 8'hFF -> p_out = 0, busy = 0, done = 0.
- Load and manual step (WIDTH = 8, LANE = 1):
  - load 8'hA5, then shift_n = 0, dir = 0, s_in = 1 -> p_out = 8'h4B;
  - then dir = 1, s_in = 0 -> 8'h25.
- Burst (LANE = 2):
  - load 8'hC3, start with count = 3, dir = 1, s_in = 2'b01 -> busy for 3 edges, then p_out = 8'h57 and done pulses once;
  - start held high during the burst is ignored.
- Abort:
  - start with count = 5, then load_n = 0 with p_in = 8'h3C on the 2nd step edge -> p_out = 8'h3C, busy = 0, no done.
- count = 0 and back-to-back bursts:
  - start with count = 0 -> done pulses one cycle later with p_out unchanged and busy never high;
  - start asserted in the done cycle is accepted.
- With SHFTREG_ROTATE_EN:
  - load 8'h81, rot = 1, burst count = 8 (LANE = 1) -> p_out = 8'h81 at done;
  - count = 1 with dir = 0 -> 8'h03.
